pll_reset_sequencer: RTL



---
 rtl/pll_reset_sequencer.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer
//
// Sequences the rPLL from the reference-clock side. It pulses the PLL reset,
// waits for LOCK, requires LOCK to stay high for a stability window and only
// then releases the downstream system reset. Lock timeouts are retried a
// bounded number of times before a fault is raised. Loss of lock while
// running re-sequences from the PLL reset pulse. Runs on the PLL input
// clock, so it keeps working while the PLL output is absent.
//
// Build option:
//   PLL_RSTSEQ_FAULT_RETRY_EN - when defined, FAULT is left after LOCK_TIMEOUT
//   cycles and sequencing restarts with a cleared retry count. The fault flag
//   then stays high until the next RUN entry. When undefined, FAULT is held
//   until reset.
//
// Ports:
//   clk          in   reference clock (same net as PLL clkin)
//   reset        in   asynchronous, active-high
//   pll_lock     in   PLL LOCK output, asynchronous to clk
//   pll_reset    out  PLL reset input, active-high
//   sys_reset    out  active-high reset for downstream logic
//   locked       out  high only in RUN
//   fault        out  high in FAULT
//   retry_count  out  failed attempts since the last RUN entry or reset

module pll_reset_sequencer #(
    parameter int unsigned PLL_RESET_CYCLES   = 32,
    parameter int unsigned LOCK_TIMEOUT       = 65536,
    parameter int unsigned LOCK_STABLE_CYCLES = 1024,
    parameter int unsigned MAX_RETRIES        = 4,
    parameter int unsigned RETRY_W            = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pll_lock,
    output logic               pll_reset,
    output logic               sys_reset,
    output logic               locked,
    output logic               fault,
    output logic [RETRY_W-1:0] retry_count
);

    localparam int unsigned CNT_MAX_A = (PLL_RESET_CYCLES > LOCK_TIMEOUT) ?
                                        PLL_RESET_CYCLES : LOCK_TIMEOUT;
    localparam int unsigned CNT_MAX   = (CNT_MAX_A > LOCK_STABLE_CYCLES) ?
                                        CNT_MAX_A : LOCK_STABLE_CYCLES;
    localparam int unsigned CNT_W     = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0]   RST_LAST    = CNT_W'(PLL_RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_LAST  = RETRY_W'(MAX_RETRIES - 1);

    typedef enum logic [2:0] {
        ST_PLL_RST,
        ST_WAIT_LOCK,
        ST_STABLE,
        ST_RUN,
        ST_FAULT
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [RETRY_W-1:0] retry_nxt;
    logic               pll_reset_nxt, sys_reset_nxt, locked_nxt, fault_nxt;

    // Two-flop synchronizer for the asynchronous LOCK output.
    logic lock_meta, lock_s;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= pll_lock;
            lock_s    <= lock_meta;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_PLL_RST;
            cnt         <= '0;
            retry_count <= '0;
            pll_reset   <= 1'b1;
            sys_reset   <= 1'b1;
            locked      <= 1'b0;
            fault       <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            retry_count <= retry_nxt;
            pll_reset   <= pll_reset_nxt;
            sys_reset   <= sys_reset_nxt;
            locked      <= locked_nxt;
            fault       <= fault_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        retry_nxt = retry_count;

        unique case (state)
            ST_PLL_RST: begin
                if (cnt == RST_LAST) begin
                    state_nxt = ST_WAIT_LOCK;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end

            ST_WAIT_LOCK: begin
                if (lock_s) begin
                    state_nxt = ST_STABLE;
                    cnt_nxt   = '0;
                end else if (cnt == TIMEOUT_LAST) begin
                    retry_nxt = retry_count + RETRY_W'(1);
                    cnt_nxt   = '0;
                    state_nxt = (retry_count == RETRY_LAST) ? ST_FAULT : ST_PLL_RST;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end

            ST_STABLE: begin
                // A low sample wins over window completion: the window must
                // be entirely high, so any dropout restarts it.
                if (!lock_s) begin
                    state_nxt = ST_WAIT_LOCK;
                    cnt_nxt   = '0;
                end else if (cnt == STABLE_LAST) begin
                    state_nxt = ST_RUN;
                    cnt_nxt   = '0;
                    retry_nxt = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end

            ST_RUN: begin
                if (!lock_s) begin
                    state_nxt = ST_PLL_RST;
                    cnt_nxt   = '0;
                end
            end

            ST_FAULT: begin
`ifdef PLL_RSTSEQ_FAULT_RETRY_EN
                if (cnt == TIMEOUT_LAST) begin
                    state_nxt = ST_PLL_RST;
                    cnt_nxt   = '0;
                    retry_nxt = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
`else
                state_nxt = ST_FAULT;
`endif
            end

            default: begin
                state_nxt = ST_PLL_RST;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they register on the same
    // edge as the state change.
    always_comb begin
        pll_reset_nxt = (state_nxt == ST_PLL_RST) || (state_nxt == ST_FAULT);
        sys_reset_nxt = (state_nxt != ST_RUN);
        locked_nxt    = (state_nxt == ST_RUN);
`ifdef PLL_RSTSEQ_FAULT_RETRY_EN
        // Fault remains visible through the automatic retry until RUN is reached.
        fault_nxt     = (state_nxt == ST_FAULT) || (fault && (state_nxt != ST_RUN));
`else
        fault_nxt     = (state_nxt == ST_FAULT);
`endif
    end

endmodule
